// File: rtl/mcp4822_pkg.sv
// Shared types and command-word helpers for the MCP4822 dual-channel DAC transmitter.
package mcp4822_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FRAME_A = 3'd1,
    GAP_A   = 3'd2,
    FRAME_B = 3'd3,
    GAP_B   = 3'd4,
    LDAC    = 3'd5
  } state_t;

  localparam int CH_SEL = 15;
  localparam int GA_N   = 13;
  localparam int SHDN_N = 12;

  function automatic logic [15:0] make_cmd(input logic ch, input logic ga_n,
                                           input logic [11:0] data);
    logic [15:0] w;
    w         = {4'b0000, data};
    w[CH_SEL] = ch;
    w[GA_N]   = ga_n;
    w[SHDN_N] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/mcp4822_frame_shifter.sv
// Serializes one 16-bit word as a mode-0 SPI frame: one idle-low phase, 16 clock pairs, ssn held low 33H.
module mcp4822_frame_shifter #(
  parameter int H = 12
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start_i,
  input  logic [15:0] word_i,
  output logic        done_o,
  output logic        sclk_o,
  output logic        ssn_o,
  output logic        mosi_o
);
  localparam int CW = (H > 1) ? $clog2(H) : 1;
  localparam logic [CW-1:0] CNT_END = CW'(H - 1);

  logic          busy_q, busy_d;
  logic          sclk_q, sclk_d;
  logic          ssn_q, ssn_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [5:0]    ph_q, ph_d;
  logic [15:0]   sh_q, sh_d;
  logic          phase_end;

  assign phase_end = busy_q && (cnt_q == CNT_END);
  assign done_o    = phase_end && (ph_q == 6'd32);
  assign sclk_o    = sclk_q;
  assign ssn_o     = ssn_q;
  assign mosi_o    = sh_q[15];

  // Phase 0 is the lead-in low, odd phases are sclk high, even phases >0 are sclk low.
  always_comb begin
    busy_d = busy_q;
    sclk_d = sclk_q;
    ssn_d  = ssn_q;
    cnt_d  = cnt_q;
    ph_d   = ph_q;
    sh_d   = sh_q;
    if (start_i) begin
      busy_d = 1'b1;
      cnt_d  = '0;
      ph_d   = '0;
      sh_d   = word_i;
      ssn_d  = 1'b0;
      sclk_d = 1'b0;
    end else if (phase_end) begin
      cnt_d = '0;
      if (ph_q == 6'd32) begin
        busy_d = 1'b0;
        ssn_d  = 1'b1;
        sh_d   = '0;
      end else begin
        ph_d   = ph_q + 6'd1;
        sclk_d = ~sclk_q;
        // The last falling edge leaves bit 0 in place until ssn rises.
        if (sclk_q && (ph_q != 6'd31)) sh_d = {sh_q[14:0], 1'b0};
      end
    end else if (busy_q) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      busy_q <= 1'b0;
      sclk_q <= 1'b0;
      ssn_q  <= 1'b1;
      cnt_q  <= '0;
      ph_q   <= '0;
      sh_q   <= '0;
    end else begin
      busy_q <= busy_d;
      sclk_q <= sclk_d;
      ssn_q  <= ssn_d;
      cnt_q  <= cnt_d;
      ph_q   <= ph_d;
      sh_q   <= sh_d;
    end
  end

endmodule

// File: rtl/mcp4822_tx.sv
// MCP4822 dual-channel transmitter: frame A, gap, frame B, gap, optional LDAC strobe.
// Define MCP4822_LDAC_SYNC_EN to update both outputs together on an LDAC pulse.
module mcp4822_tx
  import mcp4822_pkg::*;
#(
  parameter int CLOCK_FREQ = 25000000,
  parameter int SCLK_FREQ  = 1000000,
  parameter int GAIN_X2    = 0
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [11:0] ldata_i,
  input  logic [11:0] rdata_i,
  input  logic        valid_i,
  output logic        ready_o,
  output logic        spi_clk_o,
  output logic        spi_ssn_o,
  output logic        spi_mosi_o,
  output logic        spi_ldacn_o
);
  localparam int H  = CLOCK_FREQ / (2 * SCLK_FREQ);
  localparam int CW = (2 * H > 1) ? $clog2(2 * H) : 1;
  localparam logic [CW-1:0] GAP_END = CW'(2 * H - 1);
  localparam logic GA_N_BIT = (GAIN_X2 == 0);

  if (H < 1) begin : g_h_chk
    $error("mcp4822_tx: CLOCK_FREQ/(2*SCLK_FREQ) must be at least 1");
  end

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic          ready_q;
  logic [11:0]   rdata_q;
  logic          accept, gap_end, start, done;
  logic [15:0]   word;

  assign accept  = valid_i && ready_q;
  assign gap_end = (cnt_q == GAP_END);
  assign start   = accept || ((state_q == GAP_A) && gap_end);
  // Frame A comes straight from the inputs at accept; the shifter captures it on the same edge.
  assign word    = (state_q == IDLE) ? make_cmd(1'b0, GA_N_BIT, ldata_i)
                                     : make_cmd(1'b1, GA_N_BIT, rdata_q);
  assign ready_o = ready_q;

`ifdef MCP4822_LDAC_SYNC_EN
  logic ldacn_q;
  assign spi_ldacn_o = ldacn_q;
`else
  assign spi_ldacn_o = 1'b0;
`endif

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ready_q <= 1'b1;
      rdata_q <= '0;
`ifdef MCP4822_LDAC_SYNC_EN
      ldacn_q <= 1'b1;
`endif
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          state_q <= FRAME_A;
          rdata_q <= rdata_i;
          ready_q <= 1'b0;
          cnt_q   <= '0;
        end
        FRAME_A: if (done) begin
          state_q <= GAP_A;
          cnt_q   <= '0;
        end
        GAP_A: if (gap_end) begin
          state_q <= FRAME_B;
          cnt_q   <= '0;
        end else cnt_q <= cnt_q + 1'b1;
        FRAME_B: if (done) begin
          state_q <= GAP_B;
          cnt_q   <= '0;
        end
        GAP_B: if (gap_end) begin
          cnt_q   <= '0;
`ifdef MCP4822_LDAC_SYNC_EN
          state_q <= LDAC;
          ldacn_q <= 1'b0;
`else
          state_q <= IDLE;
          ready_q <= 1'b1;
`endif
        end else cnt_q <= cnt_q + 1'b1;
`ifdef MCP4822_LDAC_SYNC_EN
        LDAC: if (gap_end) begin
          state_q <= IDLE;
          ldacn_q <= 1'b1;
          ready_q <= 1'b1;
          cnt_q   <= '0;
        end else cnt_q <= cnt_q + 1'b1;
`endif
        default: state_q <= IDLE;
      endcase
    end
  end

  mcp4822_frame_shifter #(.H(H)) u_shift (
    .clock   (clock),
    .reset   (reset),
    .start_i (start),
    .word_i  (word),
    .done_o  (done),
    .sclk_o  (spi_clk_o),
    .ssn_o   (spi_ssn_o),
    .mosi_o  (spi_mosi_o)
  );

endmodule
